multi_sonar_scan_ctrl: RTL and testbench

Parametrised successor of the single-sensor pulse generator/detector. Drives NUM_CH ultrasonic sensors round-robin: warm-up, trigger pulse, then an echo high-time measurement window on the selected channel. Each result is compared against a runtime threshold to produce per-channel proximity and no-echo flags. Supports single-sweep and continuous modes and feeds the navigation/obstacle logic.

---
 rtl/sonar_pkg.sv | 24 ++
 rtl/echo_width_meter.sv | 41 ++++
 rtl/multi_sonar_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multi_sonar_scan_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the multi-channel sonar scan controller:
// FSM encodings, default 50 MHz timing constants and a sizing helper.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_WARM    = 3'd2,
        ST_TRIG    = 3'd3,
        ST_MEASURE = 3'd4,
        ST_REPORT  = 3'd5
    } sonar_state_e;

    localparam int DEF_WARM_CYC   = 50;
    localparam int DEF_TRIG_CYC   = 500;
    localparam int DEF_WINDOW_CYC = 2000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/echo_width_meter.sv
// Echo high-time meter: 2-flop synchroniser feeding a saturating counter.
// count_nxt_o is the value the counter takes at the next edge.
module echo_width_meter
    import sonar_pkg::*;
#(
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             echo_i,
    output logic [CNT_W-1:0] count_nxt_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && sync_q[1] && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            count_q <= '0;
        end else begin
            sync_q  <= clr_i ? 2'b00 : {sync_q[0], echo_i};
            count_q <= count_d;
        end
    end

    assign count_nxt_o = count_d;

endmodule

// File: rtl/multi_sonar_scan_ctrl.sv
// Round-robin ultrasonic scan controller: per enabled channel runs warm-up,
// trigger pulse and echo window, then reports count and proximity flags.
module multi_sonar_scan_ctrl
    import sonar_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 22,
    parameter int WARM_CYC   = DEF_WARM_CYC,
    parameter int TRIG_CYC   = DEF_TRIG_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              mode_cont,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [CNT_W-1:0]  thresh,
    input  logic [NUM_CH-1:0] echo_rx,
    output logic [NUM_CH-1:0] trigger,
    output logic [NUM_CH-1:0] near,
    output logic [NUM_CH-1:0] no_echo,
    output logic [CNT_W-1:0]  meas_cnt,
    output logic [CH_W-1:0]   meas_ch,
    output logic              meas_valid,
    output logic              busy,
    output logic [2:0]        state
);

    localparam int PH_W = $clog2(max3(WARM_CYC, TRIG_CYC, WINDOW_CYC) + 1);

    sonar_state_e      state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] near_q, no_echo_q;
    logic [CNT_W-1:0]  meas_cnt_q;
    logic [CH_W-1:0]   meas_ch_q;
    logic              meter_clr, load_meas;
    logic [CNT_W-1:0]  count_nxt;
    logic [CH_W-1:0]   sel_hi, sel_lo, ptr_inc;
    logic              sel_hi_found, more_above;

    // Lowest enabled channel at/above the pointer, lowest overall for the wrap,
    // and whether the captured mask has anything beyond the current channel.
    always_comb begin
        sel_hi       = '0;
        sel_lo       = '0;
        sel_hi_found = 1'b0;
        more_above   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                sel_lo = CH_W'(i);
                if (i >= int'(ptr_q)) begin
                    sel_hi       = CH_W'(i);
                    sel_hi_found = 1'b1;
                end
            end
            if (en_q[i] && (i > int'(ptr_q))) begin
                more_above = 1'b1;
            end
        end
    end

    assign ptr_inc = (int'(ptr_q) == NUM_CH - 1) ? '0 : ptr_q + CH_W'(1);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + PH_W'(1);
        ptr_d     = ptr_q;
        en_d      = en_q;
        meter_clr = 1'b0;
        load_meas = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (mode_cont || start) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                phase_d = '0;
                en_d    = ch_en;
                if (ch_en == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d   = sel_hi_found ? sel_hi : sel_lo;
                    state_d = ST_WARM;
                end
            end
            ST_WARM: begin
                if (phase_q == PH_W'(WARM_CYC - 1)) begin
                    phase_d = '0;
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (phase_q == PH_W'(TRIG_CYC - 1)) begin
                    phase_d   = '0;
                    meter_clr = 1'b1;
                    state_d   = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (phase_q == PH_W'(WINDOW_CYC - 1)) begin
                    phase_d   = '0;
                    load_meas = 1'b1;
                    state_d   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                phase_d = '0;
                ptr_d   = ptr_inc;
                state_d = (!more_above && !mode_cont) ? ST_IDLE : ST_SELECT;
            end
            default: begin
                phase_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    echo_width_meter #(
        .CNT_W(CNT_W)
    ) u_meter (
        .clk        (clk_50M),
        .rst_n      (reset),
        .clr_i      (meter_clr),
        .en_i       (state_q == ST_MEASURE),
        .echo_i     (echo_rx[ptr_q]),
        .count_nxt_o(count_nxt)
    );

    // NOTE: the result is captured from the meter's next value so it is already valid during REPORT.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            ptr_q      <= '0;
            en_q       <= '0;
            near_q     <= '0;
            no_echo_q  <= '0;
            meas_cnt_q <= '0;
            meas_ch_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            if (load_meas) begin
                meas_cnt_q <= count_nxt;
                meas_ch_q  <= ptr_q;
            end
            if (state_q == ST_REPORT) begin
                near_q[ptr_q]    <= (meas_cnt_q != '0) && (meas_cnt_q <= thresh);
                no_echo_q[ptr_q] <= (meas_cnt_q == '0);
            end
        end
    end

    // Trigger decodes straight from the state register so reset drops it asynchronously.
    assign trigger    = (state_q == ST_TRIG) ? (NUM_CH'(1) << ptr_q) : '0;
    assign near       = near_q;
    assign no_echo    = no_echo_q;
    assign meas_cnt   = meas_cnt_q;
    assign meas_ch    = meas_ch_q;
    assign meas_valid = (state_q == ST_REPORT);
    assign busy       = (state_q != ST_IDLE);
    assign state      = state_q;

endmodule

// File: tb/tb_multi_sonar_scan_ctrl.sv
// Directed bench for multi_sonar_scan_ctrl with short timing (2/5/100 cycles);
// a second instance with a 6-bit counter covers saturation.
module tb_multi_sonar_scan_ctrl;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       mode_cont, start;
    logic [3:0] ch_en, echo_rx;
    logic [7:0] thresh;
    logic [3:0] trigger, near, no_echo;
    logic [7:0] meas_cnt;
    logic [1:0] meas_ch;
    logic       meas_valid, busy;
    logic [2:0] state;

    logic       s_start;
    logic [3:0] s_ch_en, s_echo;
    logic [5:0] s_thresh;
    logic [3:0] s_trigger, s_near, s_no_echo;
    logic [5:0] s_meas_cnt;
    logic [1:0] s_meas_ch;
    logic       s_meas_valid, s_busy;
    logic [2:0] s_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int trig_cycles [4];

    always #10 clk_50M = ~clk_50M;

    multi_sonar_scan_ctrl #(
        .NUM_CH(4), .CNT_W(8), .WARM_CYC(2), .TRIG_CYC(5), .WINDOW_CYC(100)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .mode_cont(mode_cont), .start(start),
        .ch_en(ch_en), .thresh(thresh), .echo_rx(echo_rx), .trigger(trigger),
        .near(near), .no_echo(no_echo), .meas_cnt(meas_cnt), .meas_ch(meas_ch),
        .meas_valid(meas_valid), .busy(busy), .state(state)
    );

    multi_sonar_scan_ctrl #(
        .NUM_CH(4), .CNT_W(6), .WARM_CYC(2), .TRIG_CYC(5), .WINDOW_CYC(100)
    ) dut_sat (
        .clk_50M(clk_50M), .reset(reset), .mode_cont(1'b0), .start(s_start),
        .ch_en(s_ch_en), .thresh(s_thresh), .echo_rx(s_echo), .trigger(s_trigger),
        .near(s_near), .no_echo(s_no_echo), .meas_cnt(s_meas_cnt), .meas_ch(s_meas_ch),
        .meas_valid(s_meas_valid), .busy(s_busy), .state(s_state)
    );

    always @(posedge clk_50M) cyc <= cyc + 1;

    initial for (int i = 0; i < 4; i++) trig_cycles[i] = 0;

    always @(negedge clk_50M) begin
        for (int i = 0; i < 4; i++) begin
            if (trigger[i] === 1'b1) trig_cycles[i] = trig_cycles[i] + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (state !== s) begin
            bad++;
            $display("FAIL %s: state=%0d after %0d cycles, wanted %0d", tag, state, n, s);
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (meas_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (meas_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: no meas_valid within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mode_cont = 1'b0; start = 1'b0; ch_en = '0; thresh = '0; echo_rx = '0;
        s_start = 1'b0; s_ch_en = '0; s_thresh = '0; s_echo = '0;
        tick(3);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++;
        if ({trigger, near, no_echo} !== 12'd0) begin
            bad++; $display("FAIL reset_flags: trig=%b near=%b no_echo=%b want all 0", trigger, near, no_echo);
        end
        total++;
        if ({meas_cnt, meas_ch, meas_valid, busy} !== 12'd0) begin
            bad++; $display("FAIL reset_meas: cnt=%0d ch=%0d valid=%b busy=%b want 0", meas_cnt, meas_ch, meas_valid, busy);
        end
        reset = 1'b1;
        ch_en = 4'b0001;
        pulse_start();
        wait_state(3'd3, 20, "reset_reach_trig");
        total++;
        if (trigger !== 4'b0001) begin bad++; $display("FAIL trig_active: got %b want 0001", trigger); end
        tick(1);
        #5 reset = 1'b0;
        #1;
        total++;
        if (trigger !== 4'b0000) begin bad++; $display("FAIL trig_async_drop: got %b want 0000", trigger); end
        total++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_abort: state=%0d busy=%b want 0/0", state, busy);
        end
        tick(2);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_hold: state=%0d want 0", state); end
        reset = 1'b1;
        ch_en = '0;
        tick(2);
    endtask

    task automatic test_sweep();
        int snap [4];
        for (int i = 0; i < 4; i++) snap[i] = trig_cycles[i];
        thresh = 8'd30;
        ch_en  = 4'b0101;
        pulse_start();
        wait_state(3'd4, 40, "sweep_meas0");
        echo_rx[0] = 1'b1; tick(20); echo_rx[0] = 1'b0;
        wait_valid(150, "sweep_valid0");
        total++;
        if (meas_ch !== 2'd0 || meas_cnt !== 8'd20) begin
            bad++; $display("FAIL sweep_ch0: ch=%0d cnt=%0d want ch=0 cnt=20", meas_ch, meas_cnt);
        end
        tick(1);
        total++;
        if (meas_valid !== 1'b0) begin bad++; $display("FAIL strobe_width: meas_valid=%b want 0", meas_valid); end
        wait_state(3'd4, 40, "sweep_meas2");
        echo_rx[2] = 1'b1; tick(60); echo_rx[2] = 1'b0;
        wait_valid(150, "sweep_valid2");
        total++;
        if (meas_ch !== 2'd2 || meas_cnt !== 8'd60) begin
            bad++; $display("FAIL sweep_ch2: ch=%0d cnt=%0d want ch=2 cnt=60", meas_ch, meas_cnt);
        end
        wait_state(3'd0, 5, "sweep_idle");
        total++;
        if (near !== 4'b0001 || no_echo !== 4'b0000) begin
            bad++; $display("FAIL sweep_flags: near=%b no_echo=%b want 0001/0000", near, no_echo);
        end
        total++;
        if (trig_cycles[0] - snap[0] != 5 || trig_cycles[1] - snap[1] != 0 ||
            trig_cycles[2] - snap[2] != 5 || trig_cycles[3] - snap[3] != 0) begin
            bad++;
            $display("FAIL sweep_trig_cycles: got %0d %0d %0d %0d want 5 0 5 0",
                     trig_cycles[0] - snap[0], trig_cycles[1] - snap[1],
                     trig_cycles[2] - snap[2], trig_cycles[3] - snap[3]);
        end
    endtask

    task automatic test_no_echo();
        ch_en  = 4'b0010;
        thresh = 8'd30;
        pulse_start();
        wait_valid(250, "noecho_valid");
        total++;
        if (meas_ch !== 2'd1 || meas_cnt !== 8'd0) begin
            bad++; $display("FAIL noecho_meas: ch=%0d cnt=%0d want ch=1 cnt=0", meas_ch, meas_cnt);
        end
        tick(1);
        total++;
        if (no_echo !== 4'b0010 || near !== 4'b0001) begin
            bad++; $display("FAIL noecho_flags: no_echo=%b near=%b want 0010/0001", no_echo, near);
        end
        wait_state(3'd0, 5, "noecho_idle");
    endtask

    task automatic test_multi_pulse();
        ch_en  = 4'b0001;
        thresh = 8'd24;
        pulse_start();
        wait_state(3'd3, 20, "multi_trig");
        echo_rx[0] = 1'b1; tick(3); echo_rx[0] = 1'b0;
        wait_state(3'd4, 20, "multi_meas");
        tick(5);
        echo_rx[0] = 1'b1; tick(10); echo_rx[0] = 1'b0;
        tick(10);
        echo_rx[0] = 1'b1; tick(15); echo_rx[0] = 1'b0;
        wait_valid(150, "multi_valid");
        total++;
        if (meas_ch !== 2'd0 || meas_cnt !== 8'd25) begin
            bad++; $display("FAIL multi_accum: ch=%0d cnt=%0d want ch=0 cnt=25", meas_ch, meas_cnt);
        end
        tick(1);
        total++;
        if (near !== 4'b0000 || no_echo !== 4'b0010) begin
            bad++; $display("FAIL multi_flags: near=%b no_echo=%b want 0000/0010", near, no_echo);
        end
        wait_state(3'd0, 5, "multi_idle");
    endtask

    task automatic test_saturate();
        int n = 0;
        s_ch_en  = 4'b0001;
        s_thresh = 6'd40;
        s_start  = 1'b1; tick(1); s_start = 1'b0;
        while (s_state !== 3'd4 && n < 30) begin tick(1); n++; end
        s_echo[0] = 1'b1;
        n = 0;
        while (s_meas_valid !== 1'b1 && n < 150) begin tick(1); n++; end
        total++;
        if (s_meas_valid !== 1'b1 || s_meas_cnt !== 6'd63) begin
            bad++; $display("FAIL saturate_cnt: valid=%b cnt=%0d want 1/63", s_meas_valid, s_meas_cnt);
        end
        s_echo[0] = 1'b0;
        tick(1);
        total++;
        if (s_near !== 4'b0000 || s_no_echo !== 4'b0000) begin
            bad++; $display("FAIL saturate_flags: near=%b no_echo=%b want 0000/0000", s_near, s_no_echo);
        end
    endtask

    task automatic test_continuous();
        int t0, t1;
        ch_en     = 4'b1000;
        thresh    = 8'd7;
        mode_cont = 1'b1;
        wait_state(3'd4, 30, "cont_meas0");
        echo_rx[3] = 1'b1; tick(7); echo_rx[3] = 1'b0;
        wait_valid(150, "cont_valid0");
        t0 = cyc;
        total++;
        if (meas_ch !== 2'd3 || meas_cnt !== 8'd7) begin
            bad++; $display("FAIL cont_first: ch=%0d cnt=%0d want ch=3 cnt=7", meas_ch, meas_cnt);
        end
        tick(1);
        total++;
        if (near !== 4'b1000) begin bad++; $display("FAIL cont_near_eq_thresh: near=%b want 1000", near); end
        wait_valid(150, "cont_valid1");
        t1 = cyc;
        total++;
        if (t1 - t0 != 109) begin bad++; $display("FAIL cont_period: got %0d cycles want 109", t1 - t0); end
        total++;
        if (meas_ch !== 2'd3 || meas_cnt !== 8'd0) begin
            bad++; $display("FAIL cont_second: ch=%0d cnt=%0d want ch=3 cnt=0", meas_ch, meas_cnt);
        end
        tick(1);
        total++;
        if (no_echo !== 4'b1010 || near !== 4'b0000) begin
            bad++; $display("FAIL cont_flags: no_echo=%b near=%b want 1010/0000", no_echo, near);
        end
        wait_state(3'd4, 30, "cont_meas2");
        mode_cont = 1'b0;
        wait_valid(150, "cont_valid2");
        tick(1);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL cont_stop: state=%0d want 0", state); end
        tick(5);
        total++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL cont_stay_idle: state=%0d busy=%b want 0/0", state, busy);
        end
    endtask

    task automatic test_ch_en_zero();
        int strobes = 0;
        int snap [4];
        for (int i = 0; i < 4; i++) snap[i] = trig_cycles[i];
        ch_en = 4'b0000;
        pulse_start();
        total++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL zero_select: state=%0d busy=%b want 1/1", state, busy);
        end
        tick(1);
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL zero_return: state=%0d want 0", state); end
        for (int i = 0; i < 10; i++) begin
            if (meas_valid === 1'b1) strobes++;
            tick(1);
        end
        total++;
        if (strobes != 0 || trig_cycles[0] + trig_cycles[1] + trig_cycles[2] + trig_cycles[3] !=
            snap[0] + snap[1] + snap[2] + snap[3]) begin
            bad++; $display("FAIL zero_no_activity: strobes=%0d want 0, or trigger pulsed", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_no_echo();
        test_multi_pulse();
        test_saturate();
        test_continuous();
        test_ch_en_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
